// File: rtl/range_pkg.sv
// Shared types and constants for the range finder and its serial output stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package range_pkg;

    // Width of one range result, shared with the range finder.
    localparam int RANGE_W = 10;

    // Serial transmitter states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/range_uart_tx_if.sv
// Result/serial-line bundle between the range finder side and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: none on the strobe; the transmitter reports busy/buf_full/overrun instead.
// Ports: range_in/range_valid/ovr_clr driven by master; tx_out/busy/buf_full/overrun by slave.
interface range_uart_tx_if #(
    parameter int DATA_W = range_pkg::RANGE_W
);
    logic [DATA_W-1:0] range_in;
    logic              range_valid;
    logic              ovr_clr;
    logic              tx_out;
    logic              busy;
    logic              buf_full;
    logic              overrun;

    modport master (
        output range_in, range_valid, ovr_clr,
        input  tx_out, busy, buf_full, overrun
    );

    modport slave (
        input  range_in, range_valid, ovr_clr,
        output tx_out, busy, buf_full, overrun
    );
endinterface

// File: rtl/range_uart_tx_baud_gen.sv
// Bit-period timer: pulses bit_tick once every CLKS_PER_BIT cycles.
// Latency: bit_tick is combinational from the count; restart zeroes the count next cycle.
// Backpressure: none.
// Ports: clock, reset (async active-high), restart (zero the count), bit_tick (count at terminal).
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] r_cnt;

    assign bit_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart || bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/range_uart_tx.sv
// Serialises each range result into a start/data(LSB first)/[even parity]/stop frame.
// Latency: tx_out goes low 1 cycle after the strobe; frame is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: one-entry skid buffer while a frame is in flight; further strobes are dropped and set overrun.
// Ports: clock, reset (async active-high), bus (slave: range_in, range_valid, ovr_clr -> tx_out, busy, buf_full, overrun).
module range_uart_tx
    import range_pkg::*;
#(
    parameter int DATA_W       = RANGE_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic            clock,
    input  logic            reset,
    range_uart_tx_if.slave  bus
);
    localparam int BCW = $clog2(DATA_W + 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_parity;
    logic [DATA_W-1:0] r_buf;
    logic              r_buf_full;
    logic              r_overrun;
    logic              r_tx;

    logic              w_bit_tick;
    logic              w_drain;
    logic              w_load_new;
    logic              w_restart;
    logic              w_to_buf;
    logic              w_drop;
    logic [DATA_W-1:0] w_load_dat;

    // The buffer also drains from IDLE: a strobe can land in the buffer on the
    // final STOP tick while the FSM heads back to IDLE, and must not be stranded.
    assign w_drain    = r_buf_full && ((r_state == STOP && w_bit_tick) || r_state == IDLE);
    assign w_load_new = (r_state == IDLE) && !r_buf_full && bus.range_valid;
    assign w_restart  = w_drain || w_load_new;
    assign w_load_dat = r_buf_full ? r_buf : bus.range_in;

    // A strobe goes to the buffer whenever it cannot go straight to the shift reg.
    // During a drain the buffer slot frees up the same cycle, so no drop.
    assign w_to_buf = bus.range_valid && !w_load_new;
    assign w_drop   = w_to_buf && r_buf_full && !w_drain;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .restart  (w_restart),
        .bit_tick (w_bit_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            // Sticky overrun; a new drop beats a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end

            // Skid buffer: oldest queued value wins when full.
            if (w_drain) begin
                r_buf_full <= w_to_buf;
                if (w_to_buf) begin
                    r_buf <= bus.range_in;
                end
            end else if (w_to_buf && !r_buf_full) begin
                r_buf      <= bus.range_in;
                r_buf_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_restart) begin
                        r_shift   <= w_load_dat;
                        r_parity  <= ^w_load_dat;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end

                START: begin
                    if (w_bit_tick) begin
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_cnt == BCW'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            // The bit going out next is the one above the current LSB.
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    if (w_bit_tick) begin
                        if (w_drain) begin
                            // Back-to-back frame straight from the buffer, no idle gap.
                            r_shift   <= w_load_dat;
                            r_parity  <= ^w_load_dat;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
                            r_state   <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_out   = r_tx;
    assign bus.busy     = (r_state != IDLE) || r_buf_full;
    assign bus.buf_full = r_buf_full;
    assign bus.overrun  = r_overrun;
endmodule
